spi_master: RTL and testbench
=============================

# spi_master

Byte-oriented SPI master (mode 0, MSB first) on the CPU memory-mapped bus. It is a new MMIO core that sits directly downstream of the top-level CPU memory decode, at core prefix 6'h05 (byte address 0xc500_0000). It consumes the decoder's cs/we/address/write_data strobes and returns read_data/ready, which the decoder registers before presenting them to the CPU. It drives an external SPI flash/peripheral port.

## Interface
- DIV_RESET, 8'h03: reset value of the DIV register. SCK half-period is DIV+1 clk cycles.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  core select from the MMIO decoder, one access per asserted cycle.
- we  input  1  write enable; qualified by cs.
- address  input  8  word address (CPU byte address bits [9:2]).
- write_data  input  32  write data.
- read_data  output  32  read data, combinational.
- ready  output  1  access acknowledge, combinational.
- spi_ss_n  output  1  slave select, active low.
- spi_sck  output  1  serial clock.
- spi_mosi  output  1  master out.
- spi_miso  input  1  master in, asynchronous to clk.

## Operation
- Register map (word addresses):
  - 0x08 CTRL (R/W): bit0 START (write-1 pulse, reads 0); bit1 SS_EN (spi_ss_n = ~SS_EN).
  - 0x09 STATUS (RO): bit0 BUSY.
  - 0x0a DIV (R/W): bits[7:0].
  - 0x10 TXDATA (R/W): bits[7:0].
  - 0x11 RXDATA (RO): bits[7:0], last received byte.
  - All other addresses: reads 0, writes ignored. Unused read bits are 0.
- ready = cs, same cycle. No wait states.
- read_data = 0 when cs=0 or we=1.
- Writes to TXDATA and DIV while BUSY=1 are ignored.
- START while BUSY=1 is ignored.
- SS_EN is writable at any time and is never changed by the FSM.
- spi_miso passes through a 2-flop synchronizer. The sampled value is the synchronizer output. DIV must be >=2 for correct round-trip timing; this is software's responsibility, and the hardware does not clamp it.
- FSM states:
  - IDLE: sck=0.
    - START -> LOW. Load the shift register from TXDATA, set bit_cnt=0, set BUSY=1, drive mosi=TXDATA[7].
  - LOW: sck=0. Half-period counter counts 0..DIV.
    - At DIV -> HIGH. Set sck=1 and sample synchronized miso into rx_shift[0] (shift left).
  - HIGH: sck=1. Counter counts 0..DIV.
    - At DIV with bit_cnt<7 -> LOW. Set sck=0, bit_cnt+1, mosi = next MSB.
    - At DIV with bit_cnt=7 -> IDLE. Set sck=0, RXDATA = rx_shift, BUSY=0.
- mosi holds its last bit in IDLE.
- Counters: 8-bit half-period counter and 3-bit bit counter. The bit counter is not allowed to wrap.

## Timing
- Reset values:
  - spi_ss_n=1, spi_sck=0, spi_mosi=0.
  - BUSY=0, RXDATA=0, TXDATA=0, DIV=DIV_RESET, SS_EN=0, FSM=IDLE.
  - Synchronizer flops 0.
- read_data and ready are combinational, with no reset state.
- START write at edge T:
  - BUSY=1 and mosi valid after T.
  - First sck rise at T+(DIV+1).
  - Sck period is 2*(DIV+1) cycles.
  - BUSY falls and RXDATA updates at T+16*(DIV+1).
- A new START is accepted in the cycle after BUSY falls (back-to-back transfers).
- The miso sample at a rising edge reflects the pin state 2–3 clk cycles earlier.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronously), sck=0 and ss_n=1. The partial RX byte is discarded.
- A same-cycle START write and DIV write is not possible; these are separate words.

## Test plan
- Reset: assert reset_n=0 mid-simulation -> spi_ss_n=1, sck=0, mosi=0. Read DIV=0x03, STATUS=0, RXDATA=0.
- Loopback (mosi tied to miso): DIV=3, TXDATA=0xA5, CTRL=0x3 -> ss_n=0, 8 sck pulses of period 8, mosi bits 1,0,1,0,0,1,0,1. BUSY high for exactly 64 cycles, then RXDATA=0xA5.
- Slave model drives 0x3C while master sends 0xFF with DIV=2 -> RXDATA=0x3C, BUSY duration 48 cycles.
- Ignored writes while busy: mid-transfer, write TXDATA=0x00, DIV=0x10, START -> transfer completes unchanged with original data and period. TXDATA and DIV read back their old values, and no second transfer occurs.
- Reset mid-transfer after 3 bits -> sck=0, ss_n=1, BUSY=0 next sample, RXDATA=0. A new transfer then works normally.
- Bus access: reads of unmapped 0x00 and of CTRL bit0 return 0. ready equals cs every cycle, with and without we.

Source files
------------

// File: rtl/spi_master_if.sv
// ============================================================================
// Module      : spi_master_if
// Description : MMIO access bundle between the CPU memory decoder and the
//               spi_master core (select, write enable, word address, data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // Decoder side: issues accesses, receives data and acknowledge
    modport master (
        output cs,
        output we,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    // Core side: decodes accesses, returns data and acknowledge
    modport slave (
        input  cs,
        input  we,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Byte-oriented SPI master, mode 0, MSB first, memory mapped.
//               CTRL/STATUS/DIV/TXDATA/RXDATA registers; SCK half-period is
//               DIV+1 clk cycles; MISO is double-flop synchronised.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
    parameter logic [7:0] DIV_RESET = 8'h03
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    spi_master_if.slave bus,
    output logic        spi_ss_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  wire logic   spi_miso
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_DIV    = 8'h0a;
    localparam logic [7:0] ADDR_TXDATA = 8'h10;
    localparam logic [7:0] ADDR_RXDATA = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    // Software-visible registers
    logic       ss_en_q;
    logic [7:0] div_q;
    logic [7:0] txdata_q;
    logic [7:0] rxdata_q;
    logic       busy_q;

    // Transfer engine state
    state_t     state_q;
    logic [7:0] hcnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic       sck_q;
    logic       mosi_q;

    // MISO synchroniser
    logic       miso_meta_q;
    logic       miso_sync_q;

    // Bus decode
    logic        w_wr;
    logic        w_start;
    logic        w_wr_div;
    logic        w_wr_tx;
    logic        w_wr_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr      = bus.cs & bus.we;
    assign w_wr_ctrl = w_wr && (bus.address == ADDR_CTRL);
    // TXDATA, DIV and START are frozen for the duration of a transfer
    assign w_start   = w_wr_ctrl && bus.write_data[0] && !busy_q;
    assign w_wr_div  = w_wr && (bus.address == ADDR_DIV)    && !busy_q;
    assign w_wr_tx   = w_wr && (bus.address == ADDR_TXDATA) && !busy_q;
    assign w_unused  = ^bus.write_data[31:8];

    // Register read mux; reads only return data on a selected read cycle
    always_comb begin
        w_rdata = 32'd0;
        if (bus.cs && !bus.we) begin
            case (bus.address)
                ADDR_CTRL:   w_rdata = {30'd0, ss_en_q, 1'b0};
                ADDR_STATUS: w_rdata = {31'd0, busy_q};
                ADDR_DIV:    w_rdata = {24'd0, div_q};
                ADDR_TXDATA: w_rdata = {24'd0, txdata_q};
                ADDR_RXDATA: w_rdata = {24'd0, rxdata_q};
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.read_data = w_rdata;
    assign bus.ready     = bus.cs;

    assign spi_ss_n = ~ss_en_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;

    // Software-written configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_en_q  <= 1'b0;
            div_q    <= DIV_RESET;
            txdata_q <= 8'd0;
        end else begin
            if (w_wr_ctrl) ss_en_q  <= bus.write_data[1];
            if (w_wr_div)  div_q    <= bus.write_data[7:0];
            if (w_wr_tx)   txdata_q <= bus.write_data[7:0];
        end
    end

    // Two-flop synchroniser for the asynchronous MISO pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Transfer FSM: half-period timing, shifting and registered pin outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            rxdata_q   <= 8'd0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sck_q <= 1'b0;
                    if (w_start) begin
                        state_q    <= ST_LOW;
                        tx_shift_q <= txdata_q;
                        mosi_q     <= txdata_q[7];
                        hcnt_q     <= 8'd0;
                        bit_cnt_q  <= 3'd0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (hcnt_q == div_q) begin
                        state_q    <= ST_HIGH;
                        hcnt_q     <= 8'd0;
                        sck_q      <= 1'b1;
                        rx_shift_q <= {rx_shift_q[6:0], miso_sync_q};
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (hcnt_q == div_q) begin
                        hcnt_q <= 8'd0;
                        sck_q  <= 1'b0;
                        if (bit_cnt_q != 3'd7) begin
                            state_q    <= ST_LOW;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                            mosi_q     <= tx_shift_q[6];
                        end else begin
                            state_q  <= ST_IDLE;
                            rxdata_q <= rx_shift_q;
                            busy_q   <= 1'b0;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sck_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master: reset, loopback, slave
//               model, ignored writes, reset mid-transfer, back-to-back and
//               bus-access behaviour against a timing/data reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

    localparam logic [7:0] A_CTRL   = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h09;
    localparam logic [7:0] A_DIV    = 8'h0a;
    localparam logic [7:0] A_TX     = 8'h10;
    localparam logic [7:0] A_RX     = 8'h11;

    logic clk;
    logic reset_n;
    logic spi_ss_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;

    int checks   = 0;
    int failures = 0;

    // Slave / loopback model state
    logic       loop_mode  = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         slv_falls  = 0;
    int         slv_base   = 0;

    spi_master_if bus_if ();

    spi_master #(.DIV_RESET(8'h03)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .spi_ss_n (spi_ss_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: presents bit 7 before the first edge, shifts on each SCK fall
    always @(negedge spi_sck) slv_falls++;

    always_comb begin
        int idx;
        idx = slv_falls - slv_base;
        spi_miso = loop_mode ? spi_mosi : 1'b0;
        if (!loop_mode && idx >= 0 && idx < 8)
            spi_miso = slave_byte[3'(7 - idx)];
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = a; bus_if.write_data = d;
        @(posedge clk); #1;
        bus_if.cs = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.address = a;
        #1 d = bus_if.read_data;
        @(posedge clk); #1;
        bus_if.cs = 1'b0;
    endtask

    // Runs one transfer and checks every cycle against the timing model:
    // SCK high during odd half-periods, MOSI bit = tx[7 - k/(2*(DIV+1))],
    // BUSY for exactly 16*(DIV+1) cycles, 8 rising edges, RX byte correct.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] dv, input bit lp,
                            input logic [7:0] sl, input bit inject, input bit setup,
                            input bit chain);
        int total, n, rises, hp;
        logic prev_sck, exp_sck, exp_mosi, exp_busy;
        logic [7:0] exp_rx;
        logic [31:0] rd;
        hp     = int'(dv) + 1;
        total  = 16 * hp;
        n      = chain ? total : total + 12;
        exp_rx = lp ? tx : sl;
        if (setup) begin
            bus_write(A_DIV, {24'd0, dv});
            bus_write(A_TX, {24'd0, tx});
        end
        loop_mode  = lp;
        slave_byte = sl;
        slv_base   = slv_falls;
        if (setup) bus_write(A_CTRL, 32'h3);
        prev_sck = 1'b0;
        rises    = 0;
        for (int k = 0; k <= n; k++) begin
            exp_sck  = (k < total) && (((k / hp) % 2) == 1);
            exp_mosi = (k < total) ? tx[7 - (k / (2 * hp))] : tx[0];
            checks++;
            if (spi_sck !== exp_sck) begin
                failures++;
                $display("FAIL xfer_sck k=%0d got=%b exp=%b", k, spi_sck, exp_sck);
            end
            checks++;
            if (spi_mosi !== exp_mosi) begin
                failures++;
                $display("FAIL xfer_mosi k=%0d got=%b exp=%b", k, spi_mosi, exp_mosi);
            end
            checks++;
            if (spi_ss_n !== 1'b0) begin
                failures++;
                $display("FAIL xfer_ss_n k=%0d got=%b exp=0", k, spi_ss_n);
            end
            if (spi_sck === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = spi_sck;
            if (k == n) break;
            @(negedge clk);
            if (inject && k == 10) begin
                bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = A_TX;   bus_if.write_data = 32'h00;
            end else if (inject && k == 14) begin
                bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = A_DIV;  bus_if.write_data = 32'h10;
            end else if (inject && k == 18) begin
                bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = A_CTRL; bus_if.write_data = 32'h3;
            end else begin
                bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.address = A_STATUS;
                #1;
                exp_busy = (k < total);
                checks++;
                if (bus_if.read_data !== {31'd0, exp_busy}) begin
                    failures++;
                    $display("FAIL xfer_busy k=%0d got=%h exp=%h", k, bus_if.read_data, {31'd0, exp_busy});
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rises !== 8) begin
            failures++;
            $display("FAIL xfer_sck_pulses got=%0d exp=8", rises);
        end
        if (chain) begin
            // Read RXDATA, then issue the next START in the first cycle after BUSY fell
            @(negedge clk);
            bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.address = A_RX;
            #1;
            checks++;
            if (bus_if.read_data !== {24'd0, exp_rx}) begin
                failures++;
                $display("FAIL xfer_rxdata got=%h exp=%h", bus_if.read_data, exp_rx);
            end
            #1;
            bus_if.we = 1'b1; bus_if.address = A_CTRL; bus_if.write_data = 32'h3;
            @(posedge clk); #1;
            bus_if.cs = 1'b0; bus_if.we = 1'b0;
        end else begin
            bus_if.cs = 1'b0; bus_if.we = 1'b0;
            bus_read(A_RX, rd);
            checks++;
            if (rd !== {24'd0, exp_rx}) begin
                failures++;
                $display("FAIL xfer_rxdata got=%h exp=%h", rd, exp_rx);
            end
            if (inject) begin
                bus_read(A_TX, rd);
                checks++;
                if (rd !== {24'd0, tx}) begin
                    failures++;
                    $display("FAIL ignored_tx_readback got=%h exp=%h", rd, tx);
                end
                bus_read(A_DIV, rd);
                checks++;
                if (rd !== {24'd0, dv}) begin
                    failures++;
                    $display("FAIL ignored_div_readback got=%h exp=%h", rd, dv);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_write(A_DIV, 32'h07);
        bus_write(A_TX, 32'hC0);
        bus_write(A_CTRL, 32'h3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (spi_ss_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", spi_ss_n); end
        checks++;
        if (spi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
        checks++;
        if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_DIV, rd);
        checks++;
        if (rd !== 32'h03) begin failures++; $display("FAIL reset_div got=%h exp=00000003", rd); end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", rd); end
        bus_read(A_RX, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_rxdata got=%h exp=0", rd); end
        bus_read(A_TX, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_txdata got=%h exp=0", rd); end
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    endtask

    task automatic test_loopback();
        run_xfer(8'hA5, 8'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            run_xfer(8'($urandom), 8'($urandom_range(2, 5)), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_slave();
        run_xfer(8'hFF, 8'd2, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            run_xfer(8'($urandom), 8'($urandom_range(2, 5)), 1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_writes();
        run_xfer(8'h96, 8'd3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [7:0] tx;
        tx = 8'($urandom);
        bus_write(A_DIV, 32'h3);
        bus_write(A_TX, {24'd0, tx});
        loop_mode = 1'b1;
        bus_write(A_CTRL, 32'h3);
        // three full bits (24 cycles) plus into the high phase of the fourth
        repeat (29) @(posedge clk);
        #1;
        checks++;
        if (spi_sck !== 1'b1) begin failures++; $display("FAIL midreset_pre_sck got=%b exp=1", spi_sck); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (spi_sck !== 1'b0) begin failures++; $display("FAIL midreset_sck got=%b exp=0", spi_sck); end
        checks++;
        if (spi_ss_n !== 1'b1) begin failures++; $display("FAIL midreset_ss_n got=%b exp=1", spi_ss_n); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL midreset_status got=%h exp=0", rd); end
        bus_read(A_RX, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL midreset_rxdata got=%h exp=0", rd); end
        run_xfer(8'($urandom), 8'd3, 1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx;
        tx = 8'($urandom);
        run_xfer(tx, 8'd2, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
        run_xfer(tx, 8'd2, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        logic [7:0] ua;
        bus_read(8'h00, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL bus_unmapped_00 got=%h exp=0", rd); end
        ua = 8'($urandom_range(8'h20, 8'hFF));
        bus_read(ua, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL bus_unmapped_%h got=%h exp=0", ua, rd); end
        // ready follows cs, read_data is zero for writes and idle cycles
        @(negedge clk);
        bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.address = A_DIV;
        #1;
        checks++;
        if (bus_if.ready !== 1'b0) begin failures++; $display("FAIL bus_ready_idle got=%b exp=0", bus_if.ready); end
        checks++;
        if (bus_if.read_data !== 32'h0) begin failures++; $display("FAIL bus_rdata_idle got=%h exp=0", bus_if.read_data); end
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = 8'h00; bus_if.write_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus_if.ready !== 1'b1) begin failures++; $display("FAIL bus_ready_write got=%b exp=1", bus_if.ready); end
        checks++;
        if (bus_if.read_data !== 32'h0) begin failures++; $display("FAIL bus_rdata_write got=%h exp=0", bus_if.read_data); end
        bus_if.we = 1'b0; bus_if.address = A_DIV;
        #1;
        checks++;
        if (bus_if.ready !== 1'b1) begin failures++; $display("FAIL bus_ready_read got=%b exp=1", bus_if.ready); end
        @(posedge clk); #1;
        bus_if.cs = 1'b0;
        bus_write(A_CTRL, 32'h2);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL bus_ctrl_ssen got=%h exp=2", rd); end
        bus_write(A_DIV, 32'h2);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL bus_ctrl_start_reads0 got=%h exp=2", rd); end
        repeat (16 * 3 + 4) @(posedge clk);
        bus_write(A_CTRL, 32'h0);
        #1;
        checks++;
        if (spi_ss_n !== 1'b1) begin failures++; $display("FAIL bus_ss_release got=%b exp=1", spi_ss_n); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.address = 8'h00; bus_if.write_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_loopback();
        test_slave();
        test_ignored_writes();
        test_reset_mid();
        test_back_to_back();
        test_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
